// File: rtl/img2col_addr_gen_if.sv
// rtl/img2col_addr_gen_if.sv - address stream bundle between img2col_addr_gen and its consumer
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

interface img2col_addr_gen_if #(
    parameter int ADDR_W = `ADDR_SIZE
);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              patch_last;

    modport master (output addr, output addr_valid, output patch_last, input addr_ready);
    modport slave  (input addr, input addr_valid, input patch_last, output addr_ready);
endinterface

// File: rtl/img2col_addr_gen.sv
// rtl/img2col_addr_gen.sv - img2col tensor read-address generator
// IMG2COL_ADDR_GEN_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif

module img2col_addr_gen #(
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int T_W    = `TENSOR_SIZE,
    parameter int K_W    = `KERNEL_SIZE,
    parameter int C_W    = `CHANNELS_SIZE,
    parameter int S_W    = `STRIDE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    params_valid,
    input  logic                    start,
    input  logic [T_W-1:0]          tensor_size,
    input  logic [K_W-1:0]          kernel_size,
    input  logic [C_W-1:0]          channels,
    input  logic [S_W-1:0]          stride,
    input  logic [T_W-1:0]          out_dim_m1,
    img2col_addr_gen_if.master      aif,
    output logic                    busy,
    output logic                    done
`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, FINISH} state_t;
    state_t state, state_nx;

    logic [T_W-1:0]    oy, ox;
    logic [C_W-1:0]    ch;
    logic [K_W-1:0]    ky, kx;
    logic [ADDR_W-1:0] plane, row_step, row_base, win_base, ch_base, krow_base, addr_q;
    logic [ADDR_W-1:0] t_ext, s_ext, mul_b, product;
    logic [ADDR_W-1:0] krow_nx, ch_nx, win_nx, row_nx;
    logic              xfer, kx_end, ky_end, ch_end, ox_end, oy_end, final_beat, degenerate;

    assign t_ext = ADDR_W'(tensor_size);
    assign s_ext = ADDR_W'(stride);

    // One shared multiplier: T*T in SETUP, then S*T during RUN. The row step is
    // first needed at the end of an output row, which is never the first RUN beat.
    assign mul_b   = (state == SETUP) ? t_ext : s_ext;
    assign product = t_ext * mul_b;

    assign krow_nx = krow_base + t_ext;
    assign ch_nx   = ch_base + plane;
    assign win_nx  = win_base + s_ext;
    assign row_nx  = row_base + row_step;

    assign xfer       = aif.addr_valid && aif.addr_ready;
    assign kx_end     = (kx == kernel_size - K_W'(1));
    assign ky_end     = (ky == kernel_size - K_W'(1));
    assign ch_end     = (ch == channels - C_W'(1));
    assign ox_end     = (ox == out_dim_m1);
    assign oy_end     = (oy == out_dim_m1);
    assign final_beat = kx_end && ky_end && ch_end && ox_end && oy_end;
    assign degenerate = (channels == '0) || (kernel_size == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && params_valid) state_nx = SETUP;
            SETUP: begin
                if (!params_valid)   state_nx = IDLE;
                else if (degenerate) state_nx = FINISH;
                else                 state_nx = RUN;
            end
            RUN: begin
                if (!params_valid)            state_nx = IDLE;
                else if (xfer && final_beat)  state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign aif.addr_valid = (state == RUN);
    assign aif.addr       = addr_q;
    assign aif.patch_last = aif.addr_valid && kx_end && ky_end && ch_end;
    assign busy           = (state != IDLE);
    assign done           = (state == FINISH);

    // Each base register tracks one loop level, so every step is a single add.
    always_ff @(posedge clk) begin
        if (rst) begin
            oy <= '0; ox <= '0; ch <= '0; ky <= '0; kx <= '0;
            plane <= '0; row_step <= '0; row_base <= '0; win_base <= '0;
            ch_base <= '0; krow_base <= '0; addr_q <= '0;
        end else if (state == SETUP) begin
            oy <= '0; ox <= '0; ch <= '0; ky <= '0; kx <= '0;
            row_base <= '0; win_base <= '0; ch_base <= '0; krow_base <= '0; addr_q <= '0;
            plane <= product;
        end else if (state == RUN) begin
            row_step <= product;
            if (xfer) begin
                if (!kx_end) begin
                    kx     <= kx + K_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                end else if (!ky_end) begin
                    kx        <= '0;
                    ky        <= ky + K_W'(1);
                    krow_base <= krow_nx;
                    addr_q    <= krow_nx;
                end else if (!ch_end) begin
                    kx        <= '0;
                    ky        <= '0;
                    ch        <= ch + C_W'(1);
                    ch_base   <= ch_nx;
                    krow_base <= ch_nx;
                    addr_q    <= ch_nx;
                end else if (!ox_end) begin
                    kx        <= '0;
                    ky        <= '0;
                    ch        <= '0;
                    ox        <= ox + T_W'(1);
                    win_base  <= win_nx;
                    ch_base   <= win_nx;
                    krow_base <= win_nx;
                    addr_q    <= win_nx;
                end else if (!oy_end) begin
                    kx        <= '0;
                    ky        <= '0;
                    ch        <= '0;
                    ox        <= '0;
                    oy        <= oy + T_W'(1);
                    row_base  <= row_nx;
                    win_base  <= row_nx;
                    ch_base   <= row_nx;
                    krow_base <= row_nx;
                    addr_q    <= row_nx;
                end
            end
        end
    end

`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && state_nx == SETUP) begin
            stall_cnt <= '0;
        end else if (aif.addr_valid && !aif.addr_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_img2col_addr_gen.sv
// tb/tb_img2col_addr_gen.sv - scoreboard bench for img2col_addr_gen
module tb_img2col_addr_gen;
    localparam int ADDR_W = 16;
    localparam int T_W    = 8;
    localparam int K_W    = 4;
    localparam int C_W    = 8;
    localparam int S_W    = 4;

    logic           clk = 1'b0;
    logic           rst, params_valid, start;
    logic [T_W-1:0] tensor_size, out_dim_m1;
    logic [K_W-1:0] kernel_size;
    logic [C_W-1:0] channels;
    logic [S_W-1:0] stride;
    logic           busy, done;
`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    img2col_addr_gen_if #(.ADDR_W(ADDR_W)) aif ();

    img2col_addr_gen #(.ADDR_W(ADDR_W), .T_W(T_W), .K_W(K_W), .C_W(C_W), .S_W(S_W)) dut (
        .clk(clk), .rst(rst), .params_valid(params_valid), .start(start),
        .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
        .stride(stride), .out_dim_m1(out_dim_m1), .aif(aif), .busy(busy), .done(done)
`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        bit pl;
    } beat_t;

    beat_t             exp_q[$];
    beat_t             e;
    int                cap[$];
    int                n_checks = 0, n_fail = 0;
    int                cyc = 0, start_cyc = 0;
    int                beats = 0, stall_seen = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    bit                rnd_ready = 1'b0;
    bit                prev_stall = 1'b0, prev_done = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_pl;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) aif.addr_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stall hold and done width.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (aif.addr_valid && prev_stall) begin
                check("stall_hold_addr", aif.addr, prev_addr);
                check("stall_hold_last", aif.patch_last, prev_pl);
            end
            if (aif.addr_valid && aif.addr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got addr %0d, expected no beat", aif.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", aif.addr, e.a);
                    check("patch_last", aif.patch_last, e.pl);
                end
                cap.push_back(int'(aif.addr));
                beats++;
                last_xfer_cyc = cyc;
            end
            if (aif.addr_valid && !aif.addr_ready) stall_seen++;
            if (done) begin
                check("done_one_cycle", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = aif.addr_valid && !aif.addr_ready;
            prev_addr  = aif.addr;
            prev_pl    = aif.patch_last;
            prev_done  = done;
        end
    end

    task automatic push_exp(input int t, input int k, input int c, input int s, input int odm);
        beat_t b;
        for (int yy = 0; yy <= odm; yy++)
            for (int xx = 0; xx <= odm; xx++)
                for (int cc = 0; cc < c; cc++)
                    for (int yk = 0; yk < k; yk++)
                        for (int xk = 0; xk < k; xk++) begin
                            b.a  = (cc * t * t + (yy * s + yk) * t + xx * s + xk) & ((1 << ADDR_W) - 1);
                            b.pl = (cc == c - 1) && (yk == k - 1) && (xk == k - 1);
                            exp_q.push_back(b);
                        end
    endtask

    task automatic set_params(input int t, input int k, input int c, input int s, input int odm);
        tensor_size  = T_W'(t);
        kernel_size  = K_W'(k);
        channels     = C_W'(c);
        stride       = S_W'(s);
        out_dim_m1   = T_W'(odm);
        params_valid = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", done_cnt != d0, 1);
    endtask

    task automatic run_case(input int t, input int k, input int c, input int s, input int odm,
                            input bit rnd, input bit extra_start);
        int d0, n;
        set_params(t, k, c, s, odm);
        rnd_ready = rnd;
        if (!rnd) aif.addr_ready = 1'b1;
        push_exp(t, k, c, s, odm);
        n          = exp_q.size();
        beats      = 0;
        stall_seen = 0;
        cap.delete();
        d0 = done_cnt;
        pulse_start();
        if (extra_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(d0, 5000);
        check("beat_count", beats, n);
        check("queue_empty", exp_q.size(), 0);
        if (n > 0) check("done_latency", done_cyc, last_xfer_cyc + 1);
        rnd_ready      = 1'b0;
        aif.addr_ready = 1'b1;
`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, stall_seen);
`endif
        repeat (3) @(negedge clk);
        check("idle_valid", aif.addr_valid, 0);
        check("idle_busy", busy, 0);
        check("single_done", done_cnt, d0 + 1);
    endtask

    task automatic check_cap(input string name, input int idx, input int exp);
        check(name, (idx < cap.size()) ? cap[idx] : -1, exp);
    endtask

    int s1_first[8] = '{0, 1, 4, 5, 1, 2, 5, 6};
    int s2_first[8] = '{0, 1, 4, 5, 16, 17, 20, 21};
    int s2_last[8]  = '{10, 11, 14, 15, 26, 27, 30, 31};

    initial begin
        int d0, n;
        rst = 1'b1; params_valid = 1'b0; start = 1'b0; aif.addr_ready = 1'b1;
        set_params(4, 2, 1, 1, 2);
        params_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", aif.addr, 0);
        check("rst_valid", aif.addr_valid, 0);
        check("rst_patch_last", aif.patch_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef IMG2COL_ADDR_GEN_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;

        run_case(4, 2, 1, 1, 2, 1'b0, 1'b0);
        check("s1_beats", beats, 36);
        for (int i = 0; i < 8; i++) check_cap("s1_first", i, s1_first[i]);
        check_cap("s1_last", 35, 15);

        run_case(4, 2, 2, 2, 1, 1'b0, 1'b0);
        check("s2_beats", beats, 32);
        for (int i = 0; i < 8; i++) check_cap("s2_first", i, s2_first[i]);
        for (int i = 0; i < 8; i++) check_cap("s2_last", 24 + i, s2_last[i]);

        run_case(4, 2, 1, 1, 2, 1'b1, 1'b0);
        check("bp_beats", beats, 36);

        set_params(4, 2, 1, 1, 2);
        aif.addr_ready = 1'b1;
        push_exp(4, 2, 1, 1, 2);
        beats = 0;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (beats < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_beats", beats, 5);
        params_valid   = 1'b0;
        aif.addr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_valid", aif.addr_valid, 0);
        check("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        exp_q.delete();
        run_case(4, 2, 1, 1, 2, 1'b0, 1'b0);
        check_cap("restart_addr0", 0, 0);

        set_params(4, 2, 1, 1, 2);
        push_exp(4, 2, 1, 1, 2);
        d0 = done_cnt;
        pulse_start();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_addr", aif.addr, 0);
        check("midrst_valid", aif.addr_valid, 0);
        check("midrst_patch_last", aif.patch_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt, d0);

        run_case(4, 2, 2, 2, 1, 1'b0, 1'b1);
        check("busy_start_beats", beats, 32);

        run_case(4, 2, 0, 1, 2, 1'b0, 1'b0);
        check("c0_beats", beats, 0);
        check("c0_done_latency", done_cyc, start_cyc + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
